// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, fetch constants and primary opcodes.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BUBBLE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] START_PC  = 32'h40;
    localparam logic [31:0] INST_SIZE = 32'd4;
    localparam logic [31:0] NOP_INST  = 32'h0;

    // Primary opcode field values shared with the decode Controller.
    localparam logic [3:0] OP1_ALUR = 4'b0000;
    localparam logic [3:0] OP1_ALUI = 4'b1000;
    localparam logic [3:0] OP1_LW   = 4'b1001;
    localparam logic [3:0] OP1_SW   = 4'b0101;
    localparam logic [3:0] OP1_BCOND = 4'b0010;
    localparam logic [3:0] OP1_JAL  = 4'b1011;

endpackage

// File: rtl/if_dec_buffer.sv
// IF/DEC pipeline register bank; flush squashes to an invalid NOP and beats enable.
module if_dec_buffer #(
    parameter int                          DBITS          = 32,
    parameter int                          INST_BIT_WIDTH = 32,
    parameter logic [INST_BIT_WIDTH-1:0]   NOP_INST       = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      enable,
    input  logic [INST_BIT_WIDTH-1:0] inst_d,
    input  logic [DBITS-1:0]          pc_plus4_d,
    output logic                      valid,
    output logic [INST_BIT_WIDTH-1:0] inst,
    output logic [DBITS-1:0]          pc_plus4
);

    // pc_plus4 is left untouched on a flush; consumers qualify it with valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            inst     <= NOP_INST;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid    <= 1'b0;
            inst     <= NOP_INST;
        end else if (enable) begin
            valid    <= 1'b1;
            inst     <= inst_d;
            pc_plus4 <= pc_plus4_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, stall/redirect handling and IF/DEC buffer.
// Optional performance counters are compiled in with FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                        DBITS               = 32,
    parameter int                        INST_BIT_WIDTH      = 32,
    parameter logic [DBITS-1:0]          START_PC            = DBITS'(cpu_pkg::START_PC),
    parameter logic [DBITS-1:0]          INST_SIZE           = DBITS'(cpu_pkg::INST_SIZE),
    parameter int                        IMEM_ADDR_BIT_WIDTH = 11,
    parameter logic [INST_BIT_WIDTH-1:0] NOP_INST            = INST_BIT_WIDTH'(cpu_pkg::NOP_INST)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           redirect_valid,
    input  logic [DBITS-1:0]               redirect_pc,
    output logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr,
    input  logic [INST_BIT_WIDTH-1:0]      imem_data,
    output logic [DBITS-1:0]               pc_out,
    output logic                           dec_valid,
    output logic [INST_BIT_WIDTH-1:0]      dec_inst,
    output logic [DBITS-1:0]               dec_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [DBITS-1:0]               perf_fetched,
    output logic [DBITS-1:0]               perf_stalls,
    output logic [DBITS-1:0]               perf_flushes,
`endif
    output logic [1:0]                     fetch_state
);

    import cpu_pkg::*;

    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] pc_next;
    fetch_state_t     state;
    logic             advance;

    assign pc_next     = pc + INST_SIZE;
    assign imem_addr   = pc[IMEM_ADDR_BIT_WIDTH+1:2];
    assign pc_out      = pc;
    assign fetch_state = state;
    assign advance     = !redirect_valid && !stall;

    // Priority is reset, then redirect, then stall, then normal advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= START_PC;
            state <= ST_RUN;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[DBITS-1:2], 2'b00};
            state <= ST_BUBBLE;
        end else if (stall) begin
            state <= ST_HOLD;
        end else begin
            pc    <= pc_next;
            state <= ST_RUN;
        end
    end

    if_dec_buffer #(
        .DBITS          (DBITS),
        .INST_BIT_WIDTH (INST_BIT_WIDTH),
        .NOP_INST       (NOP_INST)
    ) u_if_dec_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .enable     (!stall),
        .inst_d     (imem_data),
        .pc_plus4_d (pc_next),
        .valid      (dec_valid),
        .inst       (dec_inst),
        .pc_plus4   (dec_pc_plus4)
    );

`ifdef FETCH_PERF_CNT_EN
    // A cycle with both stall and redirect counts only as a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            if (advance)
                perf_fetched <= perf_fetched + 1'b1;
            if (stall && !redirect_valid)
                perf_stalls <= perf_stalls + 1'b1;
            if (redirect_valid)
                perf_flushes <= perf_flushes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem word w holds 32'hC0DE0000 + w.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [10:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_out;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc_plus4;
    logic [1:0]  fetch_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
    logic [31:0] perf_flushes;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign imem_data = 32'hC0DE0000 + {21'd0, imem_addr};

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .pc_out         (pc_out),
        .dec_valid      (dec_valid),
        .dec_inst       (dec_inst),
        .dec_pc_plus4   (dec_pc_plus4),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls),
        .perf_flushes   (perf_flushes),
`endif
        .fetch_state    (fetch_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        check("rst_pc",       pc_out,                 32'h40);
        check("rst_valid",    {31'd0, dec_valid},     32'd0);
        check("rst_inst",     dec_inst,               32'h0);
        check("rst_plus4",    dec_pc_plus4,           32'h0);
        check("rst_state",    {30'd0, fetch_state},   32'd0);
        check("rst_addr",     {21'd0, imem_addr},     32'h10);

        reset = 1'b0;
        tick();
        check("c2_inst",      dec_inst,               32'hC0DE0010);
        check("c2_plus4",     dec_pc_plus4,           32'h44);
        check("c2_valid",     {31'd0, dec_valid},     32'd1);
        tick();
        check("c3_inst",      dec_inst,               32'hC0DE0011);
        check("c3_pc",        pc_out,                 32'h48);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",    pc_out,               32'h48);
            check("stall_inst",  dec_inst,             32'hC0DE0011);
            check("stall_state", {30'd0, fetch_state}, 32'd1);
        end
        stall = 1'b0;
        tick();
        check("unstall_inst",  dec_inst,              32'hC0DE0012);
        check("unstall_pc",    pc_out,                32'h4C);
        check("unstall_state", {30'd0, fetch_state},  32'd0);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        check("redir_pc",     pc_out,                 32'h100);
        check("redir_valid",  {31'd0, dec_valid},     32'd0);
        check("redir_inst",   dec_inst,               32'h0);
        check("redir_state",  {30'd0, fetch_state},   32'd2);
        redirect_valid = 1'b0;
        tick();
        check("tgt_inst",     dec_inst,               32'hC0DE0040);
        check("tgt_valid",    {31'd0, dec_valid},     32'd1);
        check("tgt_plus4",    dec_pc_plus4,           32'h104);

        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        check("both_pc",      pc_out,                 32'h80);
        check("both_valid",   {31'd0, dec_valid},     32'd0);
        check("both_state",   {30'd0, fetch_state},   32'd2);
        redirect_valid = 1'b0;
        tick();
        check("bstall_valid", {31'd0, dec_valid},     32'd0);
        check("bstall_pc",    pc_out,                 32'h80);
        check("bstall_state", {30'd0, fetch_state},   32'd1);
        stall = 1'b0;
        tick();
        check("b_rel_inst",   dec_inst,               32'hC0DE0020);
        check("b_rel_valid",  {31'd0, dec_valid},     32'd1);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_pc    = 32'h300;
        tick();
        check("b2b_pc",       pc_out,                 32'h300);
        check("b2b_valid",    {31'd0, dec_valid},     32'd0);
        check("b2b_state",    {30'd0, fetch_state},   32'd2);
        redirect_valid = 1'b0;
        tick();
        check("b2b_inst",     dec_inst,               32'hC0DE00C0);
        check("b2b_plus4",    dec_pc_plus4,           32'h304);

        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFE;
        tick();
        check("wrap_pc",      pc_out,                 32'hFFFFFFFC);
        check("wrap_addr",    {21'd0, imem_addr},     32'h7FF);
        redirect_valid = 1'b0;
        tick();
        check("wrap_pc0",     pc_out,                 32'h0);
        check("wrap_plus4",   dec_pc_plus4,           32'h0);
        check("wrap_addr0",   {21'd0, imem_addr},     32'h0);
        check("wrap_inst",    dec_inst,               32'hC0DE07FF);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        tick();
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched,           32'd7);
        check("perf_flushes", perf_flushes,           32'd6);
`endif
        reset          = 1'b1;
        stall          = 1'b1;
        redirect_pc    = 32'h600;
        tick();
        check("mrst_pc",      pc_out,                 32'h40);
        check("mrst_valid",   {31'd0, dec_valid},     32'd0);
        check("mrst_state",   {30'd0, fetch_state},   32'd0);
        check("mrst_inst",    dec_inst,               32'h0);
        check("mrst_plus4",   dec_pc_plus4,           32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("mrst_pfetch",  perf_fetched,           32'd0);
        check("mrst_pstall",  perf_stalls,            32'd0);
        check("mrst_pflush",  perf_flushes,           32'd0);
`endif
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        check("post_inst",    dec_inst,               32'hC0DE0010);
        check("post_pc",      pc_out,                 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
